// File: rtl/config_chain_loader_pkg.sv
// config_chain_loader_pkg
//   Shared definitions for the configuration chain loader: chain-length
//   arithmetic for a tile of logic elements and the loader state encoding.
//   No ports; imported by the loader top and its word serializer.
package config_chain_loader_pkg;

  localparam int LUT_INPUTS   = 6;
  localparam int LES_PER_TILE = 8;

  // Config bits of one LUT: its full truth table.
  function automatic int lut_conf(input int k);
    return 1 << k;
  endfunction

  // Config bits of one logic element: LUT truth table plus the FF bypass select.
  function automatic int le_conf(input int k);
    return lut_conf(k) + 1;
  endfunction

  localparam int DEFAULT_CHAIN_LENGTH = LES_PER_TILE * le_conf(LUT_INPUTS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_RELEASE = 3'd4,
    ST_DONE    = 3'd5
  } load_state_t;

endpackage

// File: rtl/config_word_serializer.sv
// config_word_serializer
//   Holds one bitstream word and presents it LSB-first, one bit per shift.
//   Ports:
//     clock, nreset   clock and synchronous active-low reset
//     load            capture word_in (takes priority over shift)
//     shift           advance to the next bit
//     word_in         word to serialise
//     bit_out         current bit (shift register LSB)
//     word_empty      high during the shift that sends the word's last bit
module config_word_serializer
  import config_chain_loader_pkg::*;
#(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WORD_WIDTH-1:0] word_in,
  output logic                  bit_out,
  output logic                  word_empty
);

  localparam int CNT_W = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

  logic [WORD_WIDTH-1:0] shreg_reg;
  logic [WORD_WIDTH-1:0] shreg_next;
  logic [CNT_W-1:0]      shift_cnt_reg;

  // Right shift by one, zero filled from the top.
  assign shreg_next[WORD_WIDTH-1] = 1'b0;
  for (genvar gi = 0; gi < WORD_WIDTH - 1; gi++) begin : g_shift
    assign shreg_next[gi] = shreg_reg[gi+1];
  end

  always_ff @(posedge clock) begin
    if (!nreset) begin
      shreg_reg     <= '0;
      shift_cnt_reg <= '0;
    end else if (load) begin
      shreg_reg     <= word_in;
      shift_cnt_reg <= '0;
    end else if (shift) begin
      shreg_reg     <= shreg_next;
      shift_cnt_reg <= shift_cnt_reg + 1'b1;
    end
  end

  assign bit_out    = shreg_reg[0];
  assign word_empty = shift && (shift_cnt_reg == LAST_BIT);

endmodule

// File: rtl/config_chain_loader.sv
// config_chain_loader
//   Streams a configuration bitstream into a tile's serial config chain,
//   LSB-first, one bit per cycle, keeping the fabric in reset until the whole
//   chain has been written, then releasing it and pulsing done.
//   Ports:
//     clock, nreset         clock and synchronous active-low reset
//     start, abort          begin a load (IDLE only) / cancel a load in progress
//     word_in, word_valid,  bitstream word stream (valid/ready)
//     word_ready
//     chain_data,           serial bit into the chain head and its shift enable
//     chain_shift
//     fabric_nreset         active-low reset for the fabric logic elements
//     busy, done, error     status: not idle / load-complete pulse / last load aborted
module config_chain_loader
  import config_chain_loader_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic                  word_valid,
  output logic                  word_ready,
  output logic                  chain_data,
  output logic                  chain_shift,
  output logic                  fabric_nreset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int BIT_CNT_W = $clog2(CHAIN_LENGTH + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_CHAIN_BIT = BIT_CNT_W'(CHAIN_LENGTH - 1);

  load_state_t          state_reg;
  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic                 word_ready_reg;
  logic                 chain_shift_reg;
  logic                 fabric_nreset_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 error_reg;

  logic ser_load;
  logic ser_bit;
  logic ser_word_empty;
  logic abortable;

  assign abortable = (state_reg == ST_CLEAR) || (state_reg == ST_LOAD) ||
                     (state_reg == ST_SHIFT) || (state_reg == ST_RELEASE);

  // word_ready is registered high exactly while in LOAD, so this is the handshake.
  // An abort in the same cycle cancels the capture.
  assign ser_load = (state_reg == ST_LOAD) && word_valid && !abort;

  config_word_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_serializer (
    .clock      (clock),
    .nreset     (nreset),
    .load       (ser_load),
    .shift      (chain_shift_reg),
    .word_in    (word_in),
    .bit_out    (ser_bit),
    .word_empty (ser_word_empty)
  );

  always_ff @(posedge clock) begin
    if (!nreset) begin
      state_reg         <= ST_IDLE;
      bit_cnt_reg       <= '0;
      word_ready_reg    <= 1'b0;
      chain_shift_reg   <= 1'b0;
      fabric_nreset_reg <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      error_reg         <= 1'b0;
    end else if (abort && abortable) begin
      // Abort beats a simultaneous start; fabric stays held in reset.
      state_reg         <= ST_IDLE;
      word_ready_reg    <= 1'b0;
      chain_shift_reg   <= 1'b0;
      fabric_nreset_reg <= 1'b0;
      busy_reg          <= 1'b0;
      done_reg          <= 1'b0;
      error_reg         <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg         <= ST_CLEAR;
            busy_reg          <= 1'b1;
            error_reg         <= 1'b0;
            fabric_nreset_reg <= 1'b0;
          end
        end
        ST_CLEAR: begin
          bit_cnt_reg    <= '0;
          state_reg      <= ST_LOAD;
          word_ready_reg <= 1'b1;
        end
        ST_LOAD: begin
          if (word_valid) begin
            state_reg       <= ST_SHIFT;
            word_ready_reg  <= 1'b0;
            chain_shift_reg <= 1'b1;
          end
        end
        ST_SHIFT: begin
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          // Chain-full check wins over word-empty: leftover word bits are dropped.
          if (bit_cnt_reg == LAST_CHAIN_BIT) begin
            state_reg         <= ST_RELEASE;
            chain_shift_reg   <= 1'b0;
            fabric_nreset_reg <= 1'b1;
          end else if (ser_word_empty) begin
            state_reg       <= ST_LOAD;
            chain_shift_reg <= 1'b0;
            word_ready_reg  <= 1'b1;
          end
        end
        ST_RELEASE: begin
          state_reg <= ST_DONE;
          done_reg  <= 1'b1;
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign word_ready    = word_ready_reg;
  // Serializer LSB is only meaningful while shifting; keep the chain input quiet otherwise.
  assign chain_data    = chain_shift_reg & ser_bit;
  assign chain_shift   = chain_shift_reg;
  assign fabric_nreset = fabric_nreset_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;

endmodule

// File: tb/tb_config_chain_loader.sv
// tb_config_chain_loader
//   Two loaders side by side: chain length 20 (partial last word) and 16
//   (exact multiple of the word width). Expected chain bits come from the
//   concatenated words, LSB-first, truncated to the chain length.
module tb_config_chain_loader;

  localparam int WW  = 8;
  localparam int CL0 = 20;
  localparam int CL1 = 16;

  logic clock  = 1'b0;
  logic nreset = 1'b0;
  always #5 clock = ~clock;

  logic [1:0]    start_v;
  logic [1:0]    abort_v;
  logic [1:0]    word_valid_v;
  logic [WW-1:0] word_in_a [2];
  logic [1:0]    word_ready_v;
  logic [1:0]    chain_data_v;
  logic [1:0]    chain_shift_v;
  logic [1:0]    fabric_nreset_v;
  logic [1:0]    busy_v;
  logic [1:0]    done_v;
  logic [1:0]    error_v;

  config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL0)) dut (
    .clock(clock), .nreset(nreset), .start(start_v[0]), .abort(abort_v[0]),
    .word_in(word_in_a[0]), .word_valid(word_valid_v[0]), .word_ready(word_ready_v[0]),
    .chain_data(chain_data_v[0]), .chain_shift(chain_shift_v[0]),
    .fabric_nreset(fabric_nreset_v[0]), .busy(busy_v[0]), .done(done_v[0]), .error(error_v[0])
  );

  config_chain_loader #(.WORD_WIDTH(WW), .CHAIN_LENGTH(CL1)) dut16 (
    .clock(clock), .nreset(nreset), .start(start_v[1]), .abort(abort_v[1]),
    .word_in(word_in_a[1]), .word_valid(word_valid_v[1]), .word_ready(word_ready_v[1]),
    .chain_data(chain_data_v[1]), .chain_shift(chain_shift_v[1]),
    .fabric_nreset(fabric_nreset_v[1]), .busy(busy_v[1]), .done(done_v[1]), .error(error_v[1])
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;

  bit exp_q0 [$];
  bit exp_q1 [$];

  int   shifts   [2] = '{0, 0};
  int   dones    [2] = '{0, 0};
  int   hs       [2] = '{0, 0};
  int   done_cyc [2] = '{0, 0};
  logic [1:0] fab_d1 = 2'b00;
  logic [1:0] fab_d2 = 2'b00;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected chain bit per observed shift.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin : mon
      bit e;
      int n;
      if (chain_shift_v[d]) begin
        shifts[d]++;
        n = (d == 0) ? exp_q0.size() : exp_q1.size();
        if (n == 0) begin
          check($sformatf("dut%0d unexpected chain_shift", d), 1, 0);
        end else begin
          if (d == 0) e = exp_q0.pop_front();
          else        e = exp_q1.pop_front();
          check($sformatf("dut%0d chain_data bit %0d", d, shifts[d]), int'(chain_data_v[d]), int'(e));
        end
      end
      if (word_ready_v[d] && word_valid_v[d]) hs[d]++;
      if (done_v[d]) begin
        dones[d]++;
        done_cyc[d] = cyc;
        check($sformatf("dut%0d fabric_nreset 1 cycle before done", d), int'(fab_d1[d]), 1);
        check($sformatf("dut%0d fabric_nreset 2 cycles before done", d), int'(fab_d2[d]), 0);
      end
      fab_d2[d] = fab_d1[d];
      fab_d1[d] = fabric_nreset_v[d];
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_model(input int d, input int cl, input logic [WW-1:0] w [$]);
    int k;
    k = 0;
    foreach (w[i]) begin
      for (int b = 0; b < WW; b++) begin
        if (k < cl) begin
          if (d == 0) exp_q0.push_back(w[i][b]);
          else        exp_q1.push_back(w[i][b]);
          k++;
        end
      end
    end
  endtask

  task automatic pulse_start(input int d);
    start_v[d] = 1'b1;
    tick();
    start_v[d] = 1'b0;
  endtask

  // Presents a word and holds it until accepted; with stall>0 first waits for
  // word_ready and then keeps word_valid low for that many cycles.
  task automatic offer(input int d, input logic [WW-1:0] w, input int stall, output bit ok);
    int guard;
    guard = 0;
    if (stall > 0) begin
      word_valid_v[d] = 1'b0;
      while (!word_ready_v[d] && guard < 200) begin tick(); guard++; end
      repeat (stall) tick();
    end
    word_in_a[d]    = w;
    word_valid_v[d] = 1'b1;
    guard = 0;
    while (!word_ready_v[d] && guard < 200) begin tick(); guard++; end
    ok = word_ready_v[d];
    tick();
  endtask

  task automatic do_load(input int d, input int cl, input logic [WW-1:0] w [$],
                         input int stall [$], input bit poke_start, input string tag);
    int s0, dn0, h0, st_cyc, guard, exp_lat, k;
    bit ok;
    s0  = shifts[d];
    dn0 = dones[d];
    h0  = hs[d];
    push_model(d, cl, w);
    exp_lat = 3;  // CLEAR, RELEASE, DONE
    k = cl;
    foreach (w[i]) begin
      exp_lat += 1 + stall[i] + ((k < WW) ? k : WW);
      k -= WW;
    end
    st_cyc = cyc;
    pulse_start(d);
    check({tag, " error after start"}, int'(error_v[d]), 0);
    check({tag, " busy after start"}, int'(busy_v[d]), 1);
    foreach (w[i]) begin
      offer(d, w[i], stall[i], ok);
      if (!ok) check({tag, " word_ready timeout"}, 0, 1);
      if (poke_start && i == 1) pulse_start(d);
    end
    if (poke_start) word_in_a[d] = 8'hFF;
    else            word_valid_v[d] = 1'b0;
    guard = 0;
    while (dones[d] == dn0 && guard < 400) begin tick(); guard++; end
    check({tag, " done latency"}, done_cyc[d] - st_cyc, exp_lat);
    repeat (4) tick();
    word_valid_v[d] = 1'b0;
    check({tag, " done pulses"}, dones[d] - dn0, 1);
    check({tag, " shift cycles"}, shifts[d] - s0, cl);
    check({tag, " handshakes"}, hs[d] - h0, w.size());
    check({tag, " leftover expected bits"}, (d == 0) ? exp_q0.size() : exp_q1.size(), 0);
    check({tag, " fabric_nreset after"}, int'(fabric_nreset_v[d]), 1);
    check({tag, " busy after"}, int'(busy_v[d]), 0);
    check({tag, " error after"}, int'(error_v[d]), 0);
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, " word_ready"},    int'(word_ready_v[d]), 0);
    check({tag, " chain_data"},    int'(chain_data_v[d]), 0);
    check({tag, " chain_shift"},   int'(chain_shift_v[d]), 0);
    check({tag, " fabric_nreset"}, int'(fabric_nreset_v[d]), 0);
    check({tag, " busy"},          int'(busy_v[d]), 0);
    check({tag, " done"},          int'(done_v[d]), 0);
    check({tag, " error"},         int'(error_v[d]), 0);
  endtask

  function automatic logic [WW-1:0] rnd_word();
    return WW'($urandom_range(0, (1 << WW) - 1));
  endfunction

  initial begin
    logic [WW-1:0] w [$];
    int st [$];
    int s0, dn0, h0, guard;
    bit ok;

    start_v = '0; abort_v = '0; word_valid_v = '0;
    word_in_a[0] = '0; word_in_a[1] = '0;
    nreset = 1'b0;
    repeat (3) tick();
    check_reset_outputs(0, "reset dut20");
    check_reset_outputs(1, "reset dut16");
    nreset = 1'b1;
    tick();

    // 1: fixed words back to back
    w = '{8'hA5, 8'h3C, 8'h0F}; st = '{0, 0, 0};
    do_load(0, CL0, w, st, 1'b0, "t1");

    // 2: same words, 5-cycle producer stall before word 2
    st = '{0, 5, 0};
    do_load(0, CL0, w, st, 1'b0, "t2");

    // 3: abort after the 10th shifted bit
    w = '{rnd_word(), rnd_word(), rnd_word()};
    push_model(0, CL0, w);
    s0 = shifts[0]; dn0 = dones[0];
    pulse_start(0);
    offer(0, w[0], 0, ok);
    offer(0, w[1], 0, ok);
    word_valid_v[0] = 1'b0;
    guard = 0;
    while (shifts[0] - s0 < 10 && guard < 100) begin tick(); guard++; end
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    check("t3 busy after abort", int'(busy_v[0]), 0);
    check("t3 error after abort", int'(error_v[0]), 1);
    check("t3 fabric_nreset after abort", int'(fabric_nreset_v[0]), 0);
    check("t3 chain_shift after abort", int'(chain_shift_v[0]), 0);
    check("t3 word_ready after abort", int'(word_ready_v[0]), 0);
    exp_q0.delete();
    repeat (30) tick();
    check("t3 no done after abort", dones[0] - dn0, 0);
    check("t3 error sticky", int'(error_v[0]), 1);
    w = '{rnd_word(), rnd_word(), rnd_word()}; st = '{0, 0, 0};
    do_load(0, CL0, w, st, 1'b0, "t3 reload");

    // 4: reset pulse mid-SHIFT
    w = '{rnd_word(), rnd_word(), rnd_word()};
    push_model(0, CL0, w);
    pulse_start(0);
    offer(0, w[0], 0, ok);
    word_valid_v[0] = 1'b0;
    repeat (3) tick();
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    check_reset_outputs(0, "t4 after nreset");
    exp_q0.delete();
    h0 = hs[0];
    word_in_a[0] = rnd_word();
    word_valid_v[0] = 1'b1;
    repeat (6) tick();
    word_valid_v[0] = 1'b0;
    check("t4 words ignored while idle", hs[0] - h0, 0);
    check("t4 still idle", int'(busy_v[0]), 0);
    w = '{rnd_word(), rnd_word(), rnd_word()}; st = '{0, 0, 0};
    do_load(0, CL0, w, st, 1'b0, "t4 reload");

    // 5: start while busy, word_valid held high through SHIFT
    w = '{rnd_word(), rnd_word(), rnd_word()}; st = '{0, 0, 0};
    do_load(0, CL0, w, st, 1'b1, "t5");

    // 6: chain length an exact multiple of the word width
    w = '{8'h81, 8'h7E}; st = '{0, 0};
    do_load(1, CL1, w, st, 1'b0, "t6");

    // randomized loads
    for (int n = 0; n < 6; n++) begin
      w = '{rnd_word(), rnd_word(), rnd_word()};
      st = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3))};
      do_load(0, CL0, w, st, 1'b0, $sformatf("rnd20_%0d", n));
    end
    for (int n = 0; n < 3; n++) begin
      w = '{rnd_word(), rnd_word()};
      st = '{int'($urandom_range(0, 3)), int'($urandom_range(0, 3))};
      do_load(1, CL1, w, st, 1'b0, $sformatf("rnd16_%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
